// File: rtl/cg_rvarch_wb_arbiter.sv
// Register-file writeback arbiter: the ALU writes directly, the LSU writes through a small FIFO.
// The ALU normally wins, and a starvation counter forces the LSU head through after STARVE_LIMIT losses.
module cg_rvarch_wb_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int DATA_NUM     = 32,
   parameter int LSU_DEPTH    = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_alu_valid,
   output logic                          o_alu_ready,
   input  logic [$clog2(DATA_NUM)-1:0]   i_alu_rd_addr,
   input  logic [DATA_WIDTH-1:0]         i_alu_rd_data,
   input  logic                          i_lsu_valid,
   output logic                          o_lsu_ready,
   input  logic [$clog2(DATA_NUM)-1:0]   i_lsu_rd_addr,
   input  logic [DATA_WIDTH-1:0]         i_lsu_rd_data,
   output logic                          o_rd_we,
   output logic [$clog2(DATA_NUM)-1:0]   o_rd_addr,
   output logic [DATA_WIDTH-1:0]         o_rd_data,
   output logic [$clog2(LSU_DEPTH):0]    o_lsu_count
);

   localparam int AW = $clog2(DATA_NUM);
   localparam int PW = $clog2(LSU_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [CW-1:0] DEPTH_C    = CW'(LSU_DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } grant_t;

   logic [AW-1:0]         fifo_addr [LSU_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [LSU_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [SW-1:0]         starve_cnt;

   logic                  fifo_empty;
   logic                  lsu_force;
   logic                  push;
   logic                  pop;
   grant_t                grant;
   logic [AW-1:0]         win_addr;
   logic [DATA_WIDTH-1:0] win_data;

   // Both ready signals come from registered state only, so a full FIFO never accepts a push
   // even when the head is being popped in the same cycle.
   assign fifo_empty  = (count == '0);
   assign lsu_force   = !fifo_empty && (starve_cnt == STARVE_MAX);
   assign o_alu_ready = !lsu_force;
   assign o_lsu_ready = (count < DEPTH_C);
   assign o_lsu_count = count;
   assign push        = i_lsu_valid && o_lsu_ready;
   assign pop         = (grant == GNT_LSU);

   always_comb begin
      grant    = GNT_NONE;
      win_addr = o_rd_addr;
      win_data = o_rd_data;
      if (i_alu_valid && !lsu_force) begin
         grant    = GNT_ALU;
         win_addr = i_alu_rd_addr;
         win_data = i_alu_rd_data;
      end else if (!fifo_empty) begin
         grant    = GNT_LSU;
         win_addr = fifo_addr[rd_ptr];
         win_data = fifo_data[rd_ptr];
      end
   end

   // Storage is not reset; the occupancy count alone decides which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= i_lsu_rd_addr;
         fifo_data[wr_ptr] <= i_lsu_rd_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // The counter only advances while the LSU actually has something waiting.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (grant == GNT_LSU) begin
         starve_cnt <= '0;
      end else if ((grant == GNT_ALU) && !fifo_empty && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rd_we   <= 1'b0;
         o_rd_addr <= '0;
         o_rd_data <= '0;
      end else begin
         o_rd_we <= (grant != GNT_NONE) && (win_addr != '0);
         if (grant != GNT_NONE) begin
            o_rd_addr <= win_addr;
            o_rd_data <= win_data;
         end
      end
   end

endmodule
